// File: rtl/kitt_pwm_decoder.sv
// Eight independent PWM capture channels: each measures high time over one frame
// and reconstructs a 3-bit brightness level, with a timeout path for 0 % / 100 % duty.
module kitt_pwm_decoder #(
  parameter int CW          = 6,
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  pwm_in,
  input  logic [2:0]  lit_thresh,
  output logic [23:0] level,
  output logic [7:0]  upd,
  output logic [7:0]  err,
  output logic [7:0]  lock,
  output logic [7:0]  lit
);

  localparam int F  = 2 ** CW;
  localparam int PW = CW + 2;
  localparam logic [PW-1:0] PC_MIN     = PW'(F - 2);
  localparam logic [PW-1:0] PC_MAX     = PW'(F + 2);
  localparam logic [PW-1:0] PC_TIMEOUT = PW'(2 * F - 1);
  localparam logic [PW-1:0] HC_CAP     = PW'(F - 1);
  localparam logic [PW-1:0] ONE        = PW'(1);

  logic [SYNC_STAGES-1:0] sync_q [8];
  logic [PW-1:0]          pc [8];
  logic [PW-1:0]          hc [8];
  logic [2:0]             meas [8];
  logic [7:0]             s;
  logic [7:0]             prev;
  logic [7:0]             rise;
  logic [7:0]             timeout;
  logic [7:0]             in_window;
  logic [7:0]             armed;

  always_comb begin
    for (int i = 0; i < 8; i++) begin
      s[i]         = sync_q[i][SYNC_STAGES-1];
      rise[i]      = s[i] & ~prev[i];
      // A rise in the timeout cycle takes priority, so timeout is masked by it.
      timeout[i]   = (pc[i] == PC_TIMEOUT) & ~rise[i];
      in_window[i] = (pc[i] >= PC_MIN) && (pc[i] <= PC_MAX);
      meas[i]      = 3'((hc[i] > HC_CAP ? HC_CAP : hc[i]) >> (CW - 3));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) begin
        sync_q[i] <= '0;
        pc[i]     <= '0;
        hc[i]     <= '0;
      end
      prev  <= '0;
      armed <= '0;
      level <= '0;
      upd   <= '0;
      err   <= '0;
      lock  <= '0;
    end else begin
      upd  <= '0;
      err  <= '0;
      prev <= s;
      for (int i = 0; i < 8; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], pwm_in[i]};
        if (rise[i]) begin
          // The rise cycle itself is high, hence both counters restart at 1.
          pc[i]    <= ONE;
          hc[i]    <= ONE;
          armed[i] <= 1'b1;
          if (armed[i]) begin
            if (in_window[i]) begin
              level[3*i +: 3] <= meas[i];
              upd[i]          <= 1'b1;
              lock[i]         <= 1'b1;
            end else begin
              err[i] <= 1'b1;
            end
          end
        end else if (timeout[i]) begin
          level[3*i +: 3] <= s[i] ? 3'd7 : 3'd0;
          upd[i]          <= 1'b1;
          lock[i]         <= 1'b1;
          armed[i]        <= 1'b0;
          pc[i]           <= ONE;
          hc[i]           <= {{(PW-1){1'b0}}, s[i]};
        end else begin
          if (pc[i] != '1) pc[i] <= pc[i] + ONE;
          if (s[i] && (hc[i] != '1)) hc[i] <= hc[i] + ONE;
        end
      end
    end
  end

  always_comb begin
    lit = '0;
    for (int i = 0; i < 8; i++) begin
      lit[i] = lock[i] & (level[3*i +: 3] >= lit_thresh);
    end
  end

endmodule

// File: tb/tb_kitt_pwm_decoder.sv
// Directed bench for kitt_pwm_decoder (CW=6, two sync stages): per-channel PWM
// generators driven cycle by cycle, with hand-computed levels and event counts.
`timescale 1ns/1ps
module tb_kitt_pwm_decoder;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  pwm_in;
  logic [2:0]  lit_thresh;
  logic [23:0] level;
  logic [7:0]  upd;
  logic [7:0]  err;
  logic [7:0]  lock;
  logic [7:0]  lit;

  kitt_pwm_decoder #(.CW(6), .SYNC_STAGES(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .pwm_in     (pwm_in),
    .lit_thresh (lit_thresh),
    .level      (level),
    .upd        (upd),
    .err        (err),
    .lock       (lock),
    .lit        (lit)
  );

  // ---------------- clock ----------------
  always #50 clk = ~clk;

  // ---------------- generator / monitor state ----------------
  int per [8];
  int hi [8];
  int nper [8];
  int nhi [8];
  int ph [8];
  int upd_cnt [8];
  int err_cnt [8];
  int both_cnt = 0;
  int n_vec = 0;
  int n_miss = 0;
  logic [23:0] exp_q [$];
  logic [23:0] exp_lvl;
  logic [23:0] got_lvl;
  logic [7:0]  exp_lit;
  int u0;
  int e0;
  int sum0;
  int sum1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    for (int i = 0; i < 8; i++) begin
      if (upd[i]) upd_cnt[i]++;
      if (err[i]) err_cnt[i]++;
      if (upd[i] && err[i]) both_cnt++;
    end
  endtask

  // One iteration = drive every line for this cycle, then take the edge.
  task automatic run(input int n);
    for (int c = 0; c < n; c++) begin
      for (int i = 0; i < 8; i++) begin
        if (ph[i] == 0) begin
          per[i] = nper[i];
          hi[i]  = nhi[i];
        end
        pwm_in[i] = (ph[i] < hi[i]);
        ph[i] = (ph[i] + 1) % per[i];
      end
      tick();
    end
  endtask

  task automatic set_ch(input int i, input int p, input int h);
    per[i] = p; nper[i] = p;
    hi[i]  = h; nhi[i]  = h;
    ph[i]  = 0;
  endtask

  task automatic frame0(input int p, input int h);
    set_ch(0, p, h);
    run(p);
  endtask

  function automatic int upd_sum();
    int t = 0;
    for (int i = 0; i < 8; i++) t += upd_cnt[i];
    return t;
  endfunction

  function automatic int err_sum();
    int t = 0;
    for (int i = 0; i < 8; i++) t += err_cnt[i];
    return t;
  endfunction

  // ---------------- directed sequence ----------------
  initial begin
    for (int i = 0; i < 8; i++) begin
      set_ch(i, 64, 0);
      upd_cnt[i] = 0;
      err_cnt[i] = 0;
    end
    pwm_in     = 8'h00;
    lit_thresh = 3'd0;
    rst        = 1'b1;

    // Reset state
    run(3);
    check("rst_level", 32'(level), 32'h0);
    check("rst_upd",   32'(upd),   32'h0);
    check("rst_err",   32'(err),   32'h0);
    check("rst_lock",  32'(lock),  32'h0);
    check("rst_lit",   32'(lit),   32'h0);
    rst = 1'b0;

    // First rise only arms; second rise (64-cycle frame, 24 high) gives level 3
    set_ch(0, 64, 24);
    run(64);
    check("t1_first_rise_no_upd", 32'(upd_cnt[0]), 32'd0);
    check("t1_no_lock_yet",       32'(lock),       32'h0);
    run(2);
    check("t1_upd_not_early", 32'(upd), 32'h0);
    run(1);
    check("t1_upd",         32'(upd),   32'h01);
    check("t1_level",       32'(level), 32'h3);
    check("t1_lock",        32'(lock),  32'h01);
    check("t1_no_err",      32'(err_cnt[0]), 32'd0);
    run(1);
    check("t1_upd_one_cycle", 32'(upd), 32'h0);

    // Duty sweep and period window on ch0
    run(60);
    frame0(64, 1);
    frame0(64, 8);
    check("t2_hi1",  32'(level[2:0]), 32'd0);
    frame0(64, 63);
    check("t2_hi8",  32'(level[2:0]), 32'd1);
    frame0(63, 16);
    check("t2_hi63", 32'(level[2:0]), 32'd7);
    frame0(65, 64);
    check("t2_per63", 32'(level[2:0]), 32'd2);
    frame0(62, 24);
    check("t2_per65_cap", 32'(level[2:0]), 32'd7);
    frame0(66, 40);
    check("t2_per62", 32'(level[2:0]), 32'd3);
    frame0(70, 56);
    check("t2_per66", 32'(level[2:0]), 32'd5);
    u0 = upd_cnt[0];
    e0 = err_cnt[0];
    frame0(64, 32);
    check("t2_per70_err",    32'(err_cnt[0] - e0), 32'd1);
    check("t2_per70_noupd",  32'(upd_cnt[0] - u0), 32'd0);
    check("t2_per70_hold",   32'(level[2:0]),      32'd5);
    u0 = upd_cnt[0];
    frame0(64, 32);
    check("t2_recover_level", 32'(level[2:0]),      32'd4);
    check("t2_recover_upd",   32'(upd_cnt[0] - u0), 32'd1);

    // ch1: lock at 3, hold high (timeout to 7), hold low (timeout to 0), resume
    set_ch(1, 64, 24);
    run(128);
    check("t3_level3", 32'(level[5:3]), 32'd3);
    check("t3_lock",   32'(lock[1]),    32'd1);
    set_ch(1, 1000, 1000);
    u0 = upd_cnt[1];
    run(129);
    check("t3_pre_timeout_level", 32'(level[5:3]),      32'd3);
    check("t3_pre_timeout_upd",   32'(upd_cnt[1] - u0), 32'd1);
    run(1);
    check("t3_timeout_upd",   32'(upd[1]),     32'd1);
    check("t3_timeout_level", 32'(level[5:3]), 32'd7);
    u0 = upd_cnt[1];
    run(126);
    check("t3_quiet_between", 32'(upd_cnt[1] - u0), 32'd0);
    run(1);
    check("t3_repeat_upd", 32'(upd[1]), 32'd1);
    set_ch(1, 64, 0);
    u0 = upd_cnt[1];
    run(127);
    check("t3_low_level", 32'(level[5:3]),      32'd0);
    check("t3_low_upd",   32'(upd_cnt[1] - u0), 32'd1);
    set_ch(1, 64, 32);
    u0 = upd_cnt[1];
    run(64);
    check("t3_resume_arm_only", 32'(upd_cnt[1] - u0), 32'd0);
    run(64);
    check("t3_resume_level", 32'(level[5:3]),      32'd4);
    check("t3_resume_upd",   32'(upd_cnt[1] - u0), 32'd1);

    // Channels at levels 0..7 and the lit threshold
    for (int i = 0; i < 8; i++) set_ch(i, 64, 8 * i + 4);
    lit_thresh = 3'd4;
    run(192);
    check("t4_levels", 32'(level), 32'hFAC688);
    check("t4_lock",   32'(lock),  32'hFF);
    check("t4_lit4",   32'(lit),   32'hF0);
    lit_thresh = 3'd0;
    #1;
    check("t4_lit0", 32'(lit), 32'hFF);
    lit_thresh = 3'd7;
    #1;
    check("t4_lit7", 32'(lit), 32'h80);
    lit_thresh = 3'd0;

    // Mid-frame reset while all lines are low
    run(61);
    check("t5_pre_lock", 32'(lock), 32'hFF);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    check("t5_rst_level", 32'(level), 32'h0);
    check("t5_rst_upd",   32'(upd),   32'h0);
    check("t5_rst_err",   32'(err),   32'h0);
    check("t5_rst_lock",  32'(lock),  32'h0);
    check("t5_rst_lit",   32'(lit),   32'h0);
    sum0 = upd_sum();
    run(66);
    check("t5_first_rise_arms", 32'(upd_sum() - sum0), 32'd0);
    check("t5_no_lock",         32'(lock),              32'h0);
    run(2);
    run(1);
    check("t5_second_rise_upd", 32'(upd),   32'hFF);
    check("t5_level",           32'(level), 32'hFAC688);
    check("t5_lock",            32'(lock),  32'hFF);

    // Random duties with independent phases, jitter-free 64-cycle frames
    run(59);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      set_ch(i, 64, int'($urandom_range(1, 63)));
      ph[i] = int'($urandom_range(hi[i], 63));
    end
    sum1 = err_sum();
    for (int r = 0; r < 10; r++) begin
      lit_thresh = 3'($urandom_range(0, 7));
      run(320);
      exp_lvl = '0;
      exp_lit = '0;
      for (int i = 0; i < 8; i++) begin
        exp_lvl[3*i +: 3] = 3'(((nhi[i] > 63) ? 63 : nhi[i]) >> 3);
        exp_lit[i] = (exp_lvl[3*i +: 3] >= lit_thresh);
      end
      exp_q.push_back(exp_lvl);
      got_lvl = exp_q.pop_front();
      check("t6_level", 32'(level), 32'(got_lvl));
      check("t6_lock",  32'(lock),  32'hFF);
      check("t6_lit",   32'(lit),   32'(exp_lit));
      for (int i = 0; i < 8; i++) nhi[i] = int'($urandom_range(1, 63));
    end
    check("t6_no_err",        32'(err_sum() - sum1), 32'd0);
    check("upd_err_exclusive", 32'(both_cnt),        32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
